// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified-memory port arbiter.
//   - FSM state encoding (legacy localparam style)
//   - owner encoding for the two requesters
//   - helper sizing the wait/timeout counter
package mem_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE   = 2'd0;
  localparam arb_state_t ACCESS = 2'd1;
  localparam arb_state_t RESP   = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // Bits needed to count 0 .. timeout-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/arb_wait_timer.sv
// Wait-state counter for the arbiter's ACCESS state.
// Ports:
//   CLK, RST  - clock (rising edge), asynchronous active-high reset
//   clear     - synchronous clear to zero (takes priority over enable)
//   enable    - count up by one per cycle
//   terminal  - high while the count equals TIMEOUT-1
module arb_wait_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int unsigned W = cnt_width(TIMEOUT);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign terminal = (count_q == W'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !terminal) begin
      // Holds at terminal so the count can never wrap.
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch
// (port 0, read-only) and data access (port 1, read/write).
// Ports:
//   CLK, RST                         - clock, asynchronous active-high reset
//   if_req/if_addr                   - fetch request, held until if_done
//   if_done/if_rdata/if_err          - fetch completion pulse, data, timeout flag
//   dm_req/dm_we/dm_addr/dm_wdata    - data request, held until dm_done
//   dm_done/dm_rdata/dm_err          - data completion pulse, data, timeout flag
//   mem_en/mem_we/mem_addr/mem_wdata - memory strobe and command
//   mem_rdata/mem_ready              - memory read data, access-complete flag
//   busy                             - arbiter not idle
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned ROUND_ROBIN = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  logic              owner_q, last_owner_q;
  logic              we_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              grant_dm;
  logic              timeout_hit;

  arb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (state_q != ACCESS),
    .enable   (state_q == ACCESS),
    .terminal (timeout_hit)
  );

  // Data wins unless fetch is alone, or round-robin says it is fetch's turn.
  always_comb begin
    grant_dm = dm_req;
    if (dm_req && if_req && (ROUND_ROBIN != 0) && (last_owner_q == OWN_DM)) begin
      grant_dm = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (if_req || dm_req) state_d = ACCESS;
      ACCESS:  if (mem_ready || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_DM;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (if_req || dm_req) begin
            err_q <= 1'b0;
            if (grant_dm) begin
              owner_q <= OWN_DM;
              we_q    <= dm_we;
              addr_q  <= dm_addr;
              wdata_q <= dm_wdata;
            end else begin
              owner_q <= OWN_IF;
              we_q    <= 1'b0;
              addr_q  <= if_addr;
              wdata_q <= '0;
            end
          end
        end
        ACCESS: begin
          // A ready arriving on the terminal cycle still counts as success.
          if (mem_ready) begin
            if (!we_q) begin
              if (owner_q == OWN_DM) dm_rdata_q <= mem_rdata;
              else                   if_rdata_q <= mem_rdata;
            end
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            if (owner_q == OWN_DM) dm_rdata_q <= '0;
            else                   if_rdata_q <= '0;
          end
        end
        RESP: begin
          last_owner_q <= owner_q;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset clears them at once.
  always_comb begin
    mem_en    = (state_q == ACCESS);
    mem_we    = mem_en & we_q;
    mem_addr  = mem_en ? addr_q  : '0;
    mem_wdata = mem_en ? wdata_q : '0;
    if_done   = (state_q == RESP) && (owner_q == OWN_IF);
    dm_done   = (state_q == RESP) && (owner_q == OWN_DM);
    if_err    = if_done & err_q;
    dm_err    = dm_done & err_q;
    busy      = (state_q != IDLE);
  end

  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;

endmodule
